mem_dump: RTL and testbench

Debug readback engine for the centralPU instruction/data memory. On a `start` request it sweeps an inclusive address range through the memory's synchronous read port and streams each word out on a valid/ready interface. It is the read-out counterpart to program loading: bench or host logic uses it to inspect results, such as the loop output at address 16, without hierarchical peeking. It sits beside `mem0` and shares its read port while the core is halted.

---
 rtl/central_pkg.sv | 17 +
 rtl/mem_dump_fifo2.sv | 52 +++++
 rtl/mem_dump.sv | 195 +++++++++++++++++++
 tb/tb_mem_dump.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/central_pkg.sv
// central_pkg: shared definitions for the centralPU memory-side blocks.
//   INSTR_SIZE        default memory word / instruction width
//   ADDR_SIZE         default memory address width
//   mem_dump_state_t  sweep FSM state encoding for mem_dump
package central_pkg;

  localparam int INSTR_SIZE = 12;
  localparam int ADDR_SIZE  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    CSUM  = 2'd3
  } mem_dump_state_t;

endpackage

// File: rtl/mem_dump_fifo2.sv
// mem_dump_fifo2: two-entry FIFO holding one packed output beat per slot.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push, wdata   write strobe and beat to store
//   pop           drop the head entry
//   rdata         head entry (meaningful while count != 0)
//   count         current occupancy, 0..2
// The caller guarantees push never happens while full.
module mem_dump_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] slots [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots[0] <= '0;
      slots[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= wdata;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = slots[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/mem_dump.sv
// mem_dump: debug readback engine. On start it reads the inclusive, wrapping
// address range first_addr..last_addr through the memory's synchronous read
// port and streams every word out on a valid/ready interface.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle request, ignored while busy
//   first_addr, last_addr  range, sampled with start
//   busy, done             sweep in progress / one-cycle completion pulse
//   mem_re, mem_addr       memory read request
//   mem_rdata              read data, valid the cycle after mem_re
//   out_valid, out_ready   output handshake
//   out_data, out_addr     beat payload
//   out_last               final beat of the sweep
// Build option: define MEM_DUMP_CHECKSUM_EN to append a checksum beat
// (sum of all words mod 2^WORD_SIZE, out_addr=0, out_last=1).
module mem_dump #(
  parameter int WORD_SIZE = central_pkg::INSTR_SIZE,
  parameter int ADDR_SIZE = central_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] first_addr,
  input  logic [ADDR_SIZE-1:0] last_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_re,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [ADDR_SIZE-1:0] out_addr,
  output logic                 out_last
);

  import central_pkg::*;

  localparam int CNT_W  = ADDR_SIZE + 1;
  localparam int BEAT_W = WORD_SIZE + ADDR_SIZE + 1;

  mem_dump_state_t state, state_next;

  logic [ADDR_SIZE-1:0] rd_addr;     // next address to read
  logic [CNT_W-1:0]     rd_cnt;      // reads still to issue
  logic [ADDR_SIZE-1:0] span;
  logic                 fl_valid;    // read issued last cycle, data on mem_rdata now
  logic [ADDR_SIZE-1:0] fl_addr;
  logic                 fl_last;
  logic                 done_q;

  logic [1:0]           fifo_count;
  logic [BEAT_W-1:0]    fifo_head;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  logic                 beat_valid;
  logic [WORD_SIZE-1:0] beat_data;
  logic [ADDR_SIZE-1:0] beat_addr;
  logic                 beat_final;
  logic                 data_accept;
  logic [1:0]           pending;
  logic                 issue;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [WORD_SIZE-1:0] sum_q;
`endif

  assign span       = last_addr - first_addr;
  assign fifo_empty = (fifo_count == 2'd0);

  // With an empty FIFO the returning read word is offered directly, which
  // gives the two-cycle start-to-beat latency; if it is not taken it is
  // parked in the FIFO so the payload stays stable.
  always_comb begin
    if (fifo_empty) begin
      beat_valid = fl_valid;
      beat_data  = mem_rdata;
      beat_addr  = fl_addr;
      beat_final = fl_last;
    end else begin
      beat_valid = 1'b1;
      beat_data  = fifo_head[BEAT_W-1 -: WORD_SIZE];
      beat_addr  = fifo_head[ADDR_SIZE:1];
      beat_final = fifo_head[0];
    end
  end

  assign data_accept = beat_valid && out_ready;
  assign pop         = !fifo_empty && out_ready;
  assign push        = fl_valid && !(fifo_empty && out_ready);

  // Buffered beats plus the read in flight never exceed the two FIFO slots.
  assign pending = fifo_count + {1'b0, fl_valid};
  assign issue   = (state == READ) &&
                   ((pending < 2'd2) || ((pending == 2'd2) && data_accept));

  mem_dump_fifo2 #(.W(BEAT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({mem_rdata, fl_addr, fl_last}),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = READ;
      READ:  if (issue && (rd_cnt == CNT_W'(1))) state_next = DRAIN;
      DRAIN: if (data_accept && beat_final) begin
`ifdef MEM_DUMP_CHECKSUM_EN
        state_next = CSUM;
`else
        state_next = IDLE;
`endif
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      CSUM:  if (out_ready) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      rd_cnt   <= '0;
      fl_valid <= 1'b0;
      fl_addr  <= '0;
      fl_last  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      done_q   <= (state != IDLE) && (state_next == IDLE);
      fl_valid <= issue;
      if (state == IDLE && start) begin
        rd_addr <= first_addr;
        rd_cnt  <= {1'b0, span} + CNT_W'(1);
      end else if (issue) begin
        rd_addr <= rd_addr + ADDR_SIZE'(1);
        rd_cnt  <= rd_cnt - CNT_W'(1);
        fl_addr <= rd_addr;
        fl_last <= (rd_cnt == CNT_W'(1));
      end
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (state == IDLE && start) begin
      sum_q <= '0;
    end else if (data_accept) begin
      sum_q <= sum_q + beat_data;
    end
  end
`endif

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    out_last  = 1'b0;
    if (beat_valid) begin
      out_valid = 1'b1;
      out_data  = beat_data;
      out_addr  = beat_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
      out_last  = 1'b0;
`else
      out_last  = beat_final;
`endif
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    if (state == CSUM) begin
      out_valid = 1'b1;
      out_data  = sum_q;
      out_addr  = '0;
      out_last  = 1'b1;
    end
`endif
  end

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign mem_re   = issue;
  assign mem_addr = rd_addr;

endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: directed, table-driven bench for mem_dump with a synchronous
// read memory model. Honours MEM_DUMP_CHECKSUM_EN when defined.
module tb_mem_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        busy;
  logic        done;
  logic        mem_re;
  logic [4:0]  mem_addr;
  logic [11:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;

  logic [11:0] mem [32];

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CSUM_BEATS = 1;
`else
  localparam int CSUM_BEATS = 0;
`endif

  typedef struct packed {
    logic [4:0]        first;
    logic [4:0]        last;
    logic              ready_alt;
    logic              poke;
    logic [2:0]        n;
    logic [0:3][4:0]   addr;
    logic [0:3][11:0]  data;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  mem_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] f, input logic [4:0] l,
                              input logic ra, input logic pk, input logic [2:0] n,
                              input logic [0:3][4:0] a, input logic [0:3][11:0] d);
    vec_t v;
    v.first = f; v.last = l; v.ready_alt = ra; v.poke = pk; v.n = n;
    v.addr = a; v.data = d;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_done"},      int'(done),      0);
    chk({tag, "_mem_re"},    int'(mem_re),    0);
    chk({tag, "_mem_addr"},  int'(mem_addr),  0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"},  int'(out_data),  0);
    chk({tag, "_out_addr"},  int'(out_addr),  0);
    chk({tag, "_out_last"},  int'(out_last),  0);
  endtask

  task automatic run_sweep(input vec_t v, input string tag);
    int          ntot;
    int          beats;
    int          issued;
    logic [11:0] sum;
    logic        pv, pacc, pl;
    logic [11:0] pd, ed;
    logic [4:0]  pa, ea;
    logic        el;
    bit          final_seen;
    bit          finished;
    ntot = int'(v.n) + CSUM_BEATS;
    beats = 0; issued = 0; sum = '0;
    pv = 1'b0; pacc = 1'b0; pl = 1'b0; pd = '0; pa = '0;
    final_seen = 1'b0; finished = 1'b0;
    for (int j = 0; j < int'(v.n); j++) sum = sum + v.data[j];

    @(negedge clk);
    start = 1'b1; first_addr = v.first; last_addr = v.last; out_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      start = v.poke && (k == 1);
      if (v.poke && k == 1) begin
        first_addr = 5'd16; last_addr = 5'd16;
      end
      out_ready = v.ready_alt ? k[0] : 1'b1;
      #1;
      if (k == 1) begin
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        chk({tag, "_mem_re_after_start"}, int'(mem_re), 1);
        chk({tag, "_mem_addr_after_start"}, int'(mem_addr), int'(v.first));
        chk({tag, "_no_beat_cycle1"}, int'(out_valid), 0);
      end
      if (final_seen) begin
        chk({tag, "_done_pulse"}, int'(done), 1);
        chk({tag, "_busy_cleared"}, int'(busy), 0);
        chk({tag, "_read_count"}, issued, int'(v.n));
        if (!v.ready_alt) chk({tag, "_done_cycle"}, k, ntot + 2);
        finished = 1'b1;
        break;
      end
      chk({tag, "_done_low"}, int'(done), 0);
      if (!v.ready_alt && k == 2) chk({tag, "_first_beat_latency"}, int'(out_valid), 1);
      if (pv && !pacc) begin
        chk({tag, "_held_valid"}, int'(out_valid), 1);
        chk({tag, "_held_data"}, int'(out_data), int'(pd));
        chk({tag, "_held_addr"}, int'(out_addr), int'(pa));
        chk({tag, "_held_last"}, int'(out_last), int'(pl));
      end
      if (mem_re) issued++;
      if (out_valid && out_ready) begin
        if (beats < int'(v.n)) begin
          ea = v.addr[beats]; ed = v.data[beats];
        end else begin
          ea = 5'd0; ed = sum;
        end
        el = (beats == ntot - 1);
        $display("beat %s #%0d addr=%0d data=0x%03h last=%0d", tag, beats, out_addr, out_data, out_last);
        chk({tag, "_beat_addr"}, int'(out_addr), int'(ea));
        chk({tag, "_beat_data"}, int'(out_data), int'(ed));
        chk({tag, "_beat_last"}, int'(out_last), int'(el));
        beats++;
        if (beats == ntot) final_seen = 1'b1;
      end
      n_cmp++;
      if (issued - beats > 2) begin
        n_bad++;
        $display("FAIL %s_outstanding: got %0d want <= 2", tag, issued - beats);
      end
      pv = out_valid; pacc = out_valid && out_ready;
      pd = out_data; pa = out_addr; pl = out_last;
    end
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d beats want %0d", tag, beats, ntot);
    end
  endtask

  initial begin
    int acc;
    bit got2;
    for (int i = 0; i < 32; i++) mem[i] = 12'h000;
    mem[0] = 12'hA05; mem[1] = 12'hC11; mem[2] = 12'hE0E;
    mem[5] = 12'h123; mem[6] = 12'h456; mem[7] = 12'h789;
    mem[16] = 12'h005; mem[30] = 12'h3C3; mem[31] = 12'hFFF;

    vecs[0] = mk(5'd0, 5'd2, 1'b0, 1'b0, 3'd3, {5'd0, 5'd1, 5'd2, 5'd0},
                 {12'hA05, 12'hC11, 12'hE0E, 12'h000});
    vecs[1] = mk(5'd30, 5'd1, 1'b0, 1'b0, 3'd4, {5'd30, 5'd31, 5'd0, 5'd1},
                 {12'h3C3, 12'hFFF, 12'hA05, 12'hC11});
    vecs[2] = mk(5'd16, 5'd16, 1'b0, 1'b0, 3'd1, {5'd16, 5'd0, 5'd0, 5'd0},
                 {12'h005, 12'h000, 12'h000, 12'h000});
    vecs[3] = mk(5'd0, 5'd2, 1'b1, 1'b0, 3'd3, {5'd0, 5'd1, 5'd2, 5'd0},
                 {12'hA05, 12'hC11, 12'hE0E, 12'h000});
    vecs[4] = mk(5'd5, 5'd7, 1'b0, 1'b1, 3'd3, {5'd5, 5'd6, 5'd7, 5'd0},
                 {12'h123, 12'h456, 12'h789, 12'h000});

    rst_n = 1'b0; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      run_sweep(vecs[t], $sformatf("vec%0d", t));
    end

    // Abort a sweep with reset after its second beat.
    @(negedge clk);
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd2; out_ready = 1'b1;
    acc = 0; got2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid && out_ready) acc++;
      if (acc == 2) begin
        got2 = 1'b1;
        break;
      end
    end
    chk("abort_setup_two_beats", int'(got2), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("abort_no_done_in_reset", int'(done), 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done_after", int'(done), 0);
      chk("abort_idle_after", int'(busy), 0);
      chk("abort_no_valid_after", int'(out_valid), 0);
    end
    run_sweep(mk(5'd0, 5'd0, 1'b0, 1'b0, 3'd1, {5'd0, 5'd0, 5'd0, 5'd0},
                 {12'hA05, 12'h000, 12'h000, 12'h000}), "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
